// File: rtl/data_sram_responder_if.sv
// Data-SRAM request/response bundle between a load/store requester (master) and the RAM responder (slave).
// Request fields are held stable by the master until req && addr_ok; responses are never backpressured.
interface data_sram_responder_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        stall;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, wr, size, addr, wstrb, wdata, stall,
      input  addr_ok, data_ok, rdata, err
   );

   modport slave (
      input  req, wr, size, addr, wstrb, wdata, stall,
      output addr_ok, data_ok, rdata, err
   );
endinterface

// File: rtl/data_sram_responder.sv
// Word RAM responder with byte strobes: data_ok exactly RD_LATENCY cycles after acceptance, in order.
// Backpressure only on the request side (addr_ok drops at MAX_OUTSTANDING or on stall); responses cannot stall.
module data_sram_responder #(
   parameter int DEPTH_WORDS     = 4096,
   parameter int RD_LATENCY      = 1,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   data_sram_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

   logic [31:0]           mem [DEPTH_WORDS];
   logic [31:0]           rd_q;
   logic [CW-1:0]         count_q;
   logic [RD_LATENCY-1:0] vld_q;
   logic [RD_LATENCY-1:0] err_q;
   logic                  ld_q;
   logic                  accept;
   logic                  err_size;
   logic                  err_req;
   logic                  resp_vld;
   logic [AW-1:0]         idx;
   logic [31:0]           stage0_dat;

   assign idx = bus.addr[AW+1:2];

   always_comb begin
      err_size = 1'b0;
      case (bus.size)
         2'd0:    err_size = 1'b0;
         2'd1:    err_size = bus.addr[0];
         2'd2:    err_size = |bus.addr[1:0];
         default: err_size = 1'b1;
      endcase
   end

   assign err_req = (|bus.addr[31:AW+2]) || err_size;

   // The slot freed by this cycle's data_ok only becomes usable next cycle.
   assign bus.addr_ok = resetn && !bus.stall && (count_q < MAX_CNT);
   assign accept      = bus.req && bus.addr_ok;

   // Single acceptance per cycle means a load never races a store in the same edge.
   always_ff @(posedge clk) begin
      if (accept && bus.wr && !err_req) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.wstrb[b]) begin
               mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
         end
      end
      if (accept && !bus.wr) begin
         rd_q <= mem[idx];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
         vld_q   <= '0;
         err_q   <= '0;
         ld_q    <= 1'b0;
      end else begin
         vld_q[0] <= accept;
         err_q[0] <= accept && err_req;
         ld_q     <= accept && !bus.wr && !err_req;
         for (int s = 1; s < RD_LATENCY; s++) begin
            vld_q[s] <= vld_q[s-1];
            err_q[s] <= err_q[s-1];
         end
         case ({accept, resp_vld})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // rd_q is unreset RAM output; only a good load lets it through.
   assign stage0_dat = ld_q ? rd_q : 32'h0;

   generate
      if (RD_LATENCY == 1) begin : g_lat1
         assign bus.rdata = stage0_dat;
      end else begin : g_latn
         logic [31:0] dat_q [RD_LATENCY-1];

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               for (int s = 0; s < RD_LATENCY - 1; s++) begin
                  dat_q[s] <= 32'h0;
               end
            end else begin
               dat_q[0] <= stage0_dat;
               for (int s = 1; s < RD_LATENCY - 1; s++) begin
                  dat_q[s] <= dat_q[s-1];
               end
            end
         end

         assign bus.rdata = dat_q[RD_LATENCY-2];
      end
   endgenerate

   assign resp_vld    = vld_q[RD_LATENCY-1];
   assign bus.data_ok = resp_vld;
   assign bus.err     = err_q[RD_LATENCY-1];
endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: three instances cover latency 1, latency 3 with a
// tight outstanding limit, and latency 2 at full throughput.
module tb_data_sram_responder;
   logic clk;
   logic resetn;
   int   n_cmp = 0;
   int   n_err = 0;

   data_sram_responder_if b1 ();
   data_sram_responder_if b3 ();
   data_sram_responder_if b2 ();

   data_sram_responder #(.DEPTH_WORDS(4096), .RD_LATENCY(1), .MAX_OUTSTANDING(2))
      u_dut1 (.clk(clk), .resetn(resetn), .bus(b1));
   data_sram_responder #(.DEPTH_WORDS(4096), .RD_LATENCY(3), .MAX_OUTSTANDING(2))
      u_dut3 (.clk(clk), .resetn(resetn), .bus(b3));
   data_sram_responder #(.DEPTH_WORDS(4096), .RD_LATENCY(2), .MAX_OUTSTANDING(3))
      u_dut2 (.clk(clk), .resetn(resetn), .bus(b2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic set1(input logic r, input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
      b1.req = r; b1.wr = w; b1.size = sz; b1.addr = a; b1.wstrb = s; b1.wdata = d;
   endtask

   task automatic set3(input logic r, input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
      b3.req = r; b3.wr = w; b3.size = sz; b3.addr = a; b3.wstrb = s; b3.wdata = d;
   endtask

   task automatic set2(input logic r, input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
      b2.req = r; b2.wr = w; b2.size = sz; b2.addr = a; b2.wstrb = s; b2.wdata = d;
   endtask

   // One latency-1 cycle: drive a request, check the response to the previous cycle's request.
   task automatic cyc1(input logic r, input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d, input logic exp_dv,
                       input logic [31:0] exp_rd, input logic exp_er, input string tag);
      step;
      set1(r, w, sz, a, s, d);
      #1;
      if (r) chk({tag, "_aok"}, 32'(b1.addr_ok), 32'd1);
      chk({tag, "_dok"}, 32'(b1.data_ok), 32'(exp_dv));
      if (exp_dv) begin
         chk({tag, "_rdata"}, b1.rdata, exp_rd);
         chk({tag, "_err"}, 32'(b1.err), 32'(exp_er));
      end
   endtask

   // Latency 3, limit 2, req held high: acceptances at c0,c1,c4,c5 (a slot freed by data_ok
   // is refilled the cycle after), responses at c3,c4,c7,c8.
   task automatic burst3(input logic w, input string tag);
      logic [9:0] aok_tab = 10'b0000110011;
      logic [9:0] dok_tab = 10'b0110011000;
      int k = 0;
      int r = 0;
      for (int c = 0; c < 10; c++) begin
         step;
         if (k < 4) set3(1'b1, w, 2'd2, 32'h40 + 32'(4 * k), 4'hF, 32'hC0DE_0000 + 32'(k));
         else       set3(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
         #1;
         if (k < 4) chk({tag, "_aok"}, 32'(b3.addr_ok), 32'(aok_tab[c]));
         chk({tag, "_dok"}, 32'(b3.data_ok), 32'(dok_tab[c]));
         if (dok_tab[c]) begin
            chk({tag, "_rdata"}, b3.rdata, w ? 32'h0 : 32'hC0DE_0000 + 32'(r));
            r++;
         end
         if (k < 4 && aok_tab[c]) k++;
      end
   endtask

   // Latency 2, limit 3: eight back-to-back requests, responses in cycles 2..9.
   task automatic burst2(input logic w, input string tag);
      for (int c = 0; c < 12; c++) begin
         step;
         if (c < 8) set2(1'b1, w, 2'd2, 32'h80 + 32'(4 * c), 4'hF, 32'h600D_0000 + 32'(c * 17));
         else       set2(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
         #1;
         if (c < 8) chk({tag, "_aok"}, 32'(b2.addr_ok), 32'd1);
         chk({tag, "_dok"}, 32'(b2.data_ok), 32'((c >= 2) && (c < 10)));
         if ((c >= 2) && (c < 10))
            chk({tag, "_rdata"}, b2.rdata, w ? 32'h0 : 32'h600D_0000 + 32'((c - 2) * 17));
      end
   endtask

   initial begin
      resetn = 1'b0;
      b1.stall = 1'b0; b3.stall = 1'b0; b2.stall = 1'b0;
      set1(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
      set3(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
      set2(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);

      // Reset state
      step;
      step;
      chk("rst_aok1", 32'(b1.addr_ok), 32'd0);
      chk("rst_dok1", 32'(b1.data_ok), 32'd0);
      chk("rst_rdata1", b1.rdata, 32'h0);
      chk("rst_err1", 32'(b1.err), 32'd0);
      chk("rst_aok3", 32'(b3.addr_ok), 32'd0);
      chk("rst_rdata2", b2.rdata, 32'h0);
      resetn = 1'b1;
      step;
      chk("post_rst_aok1", 32'(b1.addr_ok), 32'd1);
      chk("post_rst_dok3", 32'(b3.data_ok), 32'd0);

      // Reset with two loads in flight (latency 3)
      step; set3(1'b1, 1'b1, 2'd2, 32'h20, 4'hF, 32'h5A5A_1234); #1;
      chk("t1_st_aok", 32'(b3.addr_ok), 32'd1);
      step; set3(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0); #1;
      chk("t1_st_dok_c1", 32'(b3.data_ok), 32'd0);
      step; #1;
      chk("t1_st_dok_c2", 32'(b3.data_ok), 32'd0);
      step; #1;
      chk("t1_st_dok_c3", 32'(b3.data_ok), 32'd1);
      chk("t1_st_rdata", b3.rdata, 32'h0);
      step; set3(1'b1, 1'b0, 2'd2, 32'h20, 4'h0, 32'h0); #1;
      chk("t1_ld0_aok", 32'(b3.addr_ok), 32'd1);
      step; set3(1'b1, 1'b0, 2'd2, 32'h24, 4'h0, 32'h0); #1;
      chk("t1_ld1_aok", 32'(b3.addr_ok), 32'd1);
      step; set3(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
      resetn = 1'b0;
      #1;
      chk("t1_rst_aok", 32'(b3.addr_ok), 32'd0);
      chk("t1_rst_dok", 32'(b3.data_ok), 32'd0);
      chk("t1_rst_rdata", b3.rdata, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step;
         chk("t1_rst_hold_dok", 32'(b3.data_ok), 32'd0);
         chk("t1_rst_hold_aok", 32'(b3.addr_ok), 32'd0);
      end
      step;
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step;
         chk("t1_post_dok", 32'(b3.data_ok), 32'd0);
      end
      step; set3(1'b1, 1'b0, 2'd2, 32'h20, 4'h0, 32'h0); #1;
      chk("t1_new_aok", 32'(b3.addr_ok), 32'd1);
      step; set3(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0); #1;
      chk("t1_new_dok_e1", 32'(b3.data_ok), 32'd0);
      step; #1;
      chk("t1_new_dok_e2", 32'(b3.data_ok), 32'd0);
      step; #1;
      chk("t1_new_dok", 32'(b3.data_ok), 32'd1);
      chk("t1_new_rdata", b3.rdata, 32'h5A5A_1234);
      chk("t1_new_err", 32'(b3.err), 32'd0);

      // Store then load, latency 1
      cyc1(1'b1, 1'b1, 2'd2, 32'h100, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, "t2_st");
      cyc1(1'b1, 1'b0, 2'd2, 32'h100, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0, "t2_ld");
      cyc1(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, "t2_rsp");

      // Byte strobe merge
      cyc1(1'b1, 1'b1, 2'd2, 32'h104, 4'hF, 32'h1122_3344, 1'b0, 32'h0, 1'b0, "t3_st_word");
      cyc1(1'b1, 1'b1, 2'd0, 32'h107, 4'b1000, 32'hAA00_0000, 1'b1, 32'h0, 1'b0, "t3_st_byte");
      cyc1(1'b1, 1'b0, 2'd2, 32'h104, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0, "t3_ld");
      cyc1(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b1, 32'hAA22_3344, 1'b0, "t3_rsp");

      // Error cases; the out-of-range store aliases word 0 if not suppressed
      cyc1(1'b1, 1'b1, 2'd2, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0, "t4_st0");
      cyc1(1'b1, 1'b0, 2'd2, 32'h102, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0, "t4_ld_misal_w");
      cyc1(1'b1, 1'b1, 2'd2, 32'h0001_0000, 4'hF, 32'h1234_5678, 1'b1, 32'h0, 1'b1, "t4_st_oob");
      cyc1(1'b1, 1'b0, 2'd1, 32'h103, 4'h0, 32'h0, 1'b1, 32'h0, 1'b1, "t4_ld_misal_h");
      cyc1(1'b1, 1'b0, 2'd3, 32'h100, 4'h0, 32'h0, 1'b1, 32'h0, 1'b1, "t4_ld_size3");
      cyc1(1'b1, 1'b0, 2'd0, 32'h101, 4'h0, 32'h0, 1'b1, 32'h0, 1'b1, "t4_ld_byte");
      cyc1(1'b1, 1'b0, 2'd2, 32'h0, 4'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, "t4_ld0");
      cyc1(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b0, "t4_rsp0");
      cyc1(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, "t4_idle");

      // Backpressure from the outstanding limit, then stall
      burst3(1'b1, "t5_st");
      burst3(1'b0, "t5_ld");
      step; b3.stall = 1'b1; set3(1'b1, 1'b0, 2'd2, 32'h44, 4'h0, 32'h0); #1;
      chk("t5_stall_aok", 32'(b3.addr_ok), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step;
         chk("t5_stall_aok_hold", 32'(b3.addr_ok), 32'd0);
         chk("t5_stall_dok", 32'(b3.data_ok), 32'd0);
      end
      step; b3.stall = 1'b0; #1;
      chk("t5_unstall_aok", 32'(b3.addr_ok), 32'd1);
      step; set3(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
      step;
      step; #1;
      chk("t5_unstall_dok", 32'(b3.data_ok), 32'd1);
      chk("t5_unstall_rdata", b3.rdata, 32'hC0DE_0001);

      // Full throughput, latency 2
      burst2(1'b1, "t6_st");
      burst2(1'b0, "t6_ld");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
